// File: rtl/adc_seq_pkg.sv
// Shared constants for the ADC scan sequencer: register map, CSR bit indices, FSM states.
package adc_seq_pkg;

  localparam logic [5:0] AddrCtrl   = 6'h00;
  localparam logic [5:0] AddrStatus = 6'h01;
  localparam logic [5:0] AddrIrqEn  = 6'h02;
  localparam logic [5:0] AddrMaxSeq = 6'h03;
  localparam logic [5:0] AddrTstamp = 6'h04;

  // Paged regions are selected by MMS_address[5:4]; [3:0] is the slot index.
  localparam logic [1:0] PageChMap  = 2'b01;
  localparam logic [1:0] PageResult = 2'b10;

  localparam int unsigned CtrlEn        = 0;
  localparam int unsigned CtrlCont      = 1;
  localparam int unsigned CtrlTrigSelLo = 2;

  localparam int unsigned StatDone    = 0;
  localparam int unsigned StatOverrun = 1;
  localparam int unsigned StatChErr   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWaitResp
  } seq_state_e;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Command stream, ADC response stream and CSR slave bundled for the scan sequencer.
interface adc_scan_sequencer_if #(
  parameter int unsigned CH_W   = 5,
  parameter int unsigned DATA_W = 12
);
  logic              chout_ready;
  logic              chout_valid;
  logic [CH_W-1:0]   chout_data;
  logic              chout_startofpacket;
  logic              chout_endofpacket;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [CH_W-1:0]   resp_channel;
  logic              resp_startofpacket;
  logic              resp_endofpacket;

  logic              MMS_read;
  logic              MMS_write;
  logic [5:0]        MMS_address;
  logic [31:0]       MMS_writedata;
  logic [31:0]       MMS_readdata;

  modport slave (
    input  chout_ready,
    output chout_valid, chout_data, chout_startofpacket, chout_endofpacket,
    input  resp_valid, resp_data, resp_channel, resp_startofpacket, resp_endofpacket,
    input  MMS_read, MMS_write, MMS_address, MMS_writedata,
    output MMS_readdata
  );

  modport master (
    output chout_ready,
    input  chout_valid, chout_data, chout_startofpacket, chout_endofpacket,
    output resp_valid, resp_data, resp_channel, resp_startofpacket, resp_endofpacket,
    output MMS_read, MMS_write, MMS_address, MMS_writedata,
    input  MMS_readdata
  );
endinterface

// File: rtl/adc_seq_result_bank.sv
// Double-buffered sample storage: responses land in a shadow bank, commit copies it whole.
module adc_seq_result_bank #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        shadow_q[i] <= '0;
        result_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_en && wr_idx == 4'(i)) shadow_q[i] <= wr_data;
        // A beat written in the commit cycle goes straight into the result bank.
        if (commit) result_q[i] <= (wr_en && wr_idx == 4'(i)) ? wr_data : shadow_q[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_idx == 4'(i)) rd_data = result_q[i];
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: issues a channel list per trigger and double-buffers the samples.
// Optional feature: define ADC_SEQ_TIMESTAMP_EN for the trigger timestamp register.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SEQ_DEPTH = 8,
  parameter int unsigned CH_W      = 5,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned TRIG_N    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TRIG_N-1:0] trig_in,
  output logic              irq_out,
  adc_scan_sequencer_if.slave bus
);

  localparam logic [3:0] MaxSlot = 4'(SEQ_DEPTH - 1);

  logic [3:0]        ctrl_q;
  logic [2:0]        status_q, status_d, status_set, status_clr;
  logic [2:0]        irq_en_q;
  logic [3:0]        maxseq_q;
  logic [CH_W-1:0]   ch_map_q [SEQ_DEPTH];
  logic [TRIG_N-1:0] trig_prev_q;
  logic              irq_q;
  seq_state_e        state_q;
  logic [3:0]        slot_q;
  logic [4:0]        resp_ctr_q;

  logic [1:0]        trig_sel;
  logic              trig_edge;
  logic              en_next;
  logic [4:0]        resp_idx;
  logic              resp_store;
  logic              commit;
  logic [CH_W-1:0]   cmd_ch, exp_ch;
  logic [DATA_W-1:0] bank_rd_data;
  logic [31:0]       ts_rdata;
  logic [3:0]        wr_maxseq;

  logic unused_bits;
  assign unused_bits = ^{bus.MMS_read, bus.MMS_writedata[31:4]};

  assign trig_sel = ctrl_q[CtrlTrigSelLo +: 2];
  // Clearing EN takes effect on the write's own clock edge.
  assign en_next  = (bus.MMS_write && bus.MMS_address == AddrCtrl) ? bus.MMS_writedata[CtrlEn]
                                                                    : ctrl_q[CtrlEn];

  always_comb begin
    trig_edge = 1'b0;
    for (int i = 0; i < int'(TRIG_N); i++) begin
      if (trig_sel == 2'(i)) trig_edge = trig_in[i] & ~trig_prev_q[i];
    end
  end

  assign resp_idx   = bus.resp_startofpacket ? 5'd0 : resp_ctr_q;
  assign resp_store = bus.resp_valid && (state_q != StIdle) && (resp_idx <= {1'b0, maxseq_q});
  assign commit     = (state_q == StWaitResp) && bus.resp_valid && bus.resp_endofpacket;

  always_comb begin
    cmd_ch = '0;
    exp_ch = '0;
    for (int i = 0; i < int'(SEQ_DEPTH); i++) begin
      if (slot_q == 4'(i))   cmd_ch = ch_map_q[i];
      if (resp_idx == 5'(i)) exp_ch = ch_map_q[i];
    end
  end

  always_comb begin
    status_set = '0;
    status_set[StatDone]    = commit;
    status_set[StatOverrun] = trig_edge && (state_q != StIdle);
    status_set[StatChErr]   = resp_store && (bus.resp_channel != exp_ch);
    status_clr = (bus.MMS_write && bus.MMS_address == AddrStatus) ? bus.MMS_writedata[2:0]
                                                                   : 3'b000;
    status_d   = (status_q & ~status_clr) | status_set;
  end

  assign wr_maxseq = (bus.MMS_writedata[3:0] > MaxSlot) ? MaxSlot : bus.MMS_writedata[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      status_q    <= '0;
      irq_en_q    <= '0;
      maxseq_q    <= '0;
      trig_prev_q <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < int'(SEQ_DEPTH); i++) ch_map_q[i] <= '0;
    end else begin
      trig_prev_q <= trig_in;
      status_q    <= status_d;
      irq_q       <= |(status_q & irq_en_q);
      if (bus.MMS_write) begin
        case (bus.MMS_address)
          AddrCtrl:   ctrl_q   <= bus.MMS_writedata[3:0];
          AddrIrqEn:  irq_en_q <= bus.MMS_writedata[2:0];
          AddrMaxSeq: maxseq_q <= wr_maxseq;
          default: ;
        endcase
        for (int i = 0; i < int'(SEQ_DEPTH); i++) begin
          if (bus.MMS_address == {PageChMap, 4'(i)}) ch_map_q[i] <= bus.MMS_writedata[CH_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      resp_ctr_q <= '0;
    end else if (!en_next) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      resp_ctr_q <= '0;
    end else begin
      if (resp_store) resp_ctr_q <= resp_idx + 5'd1;
      case (state_q)
        StIdle: begin
          if (trig_edge && ctrl_q[CtrlEn]) begin
            state_q    <= StRun;
            slot_q     <= '0;
            resp_ctr_q <= '0;
          end
        end
        StRun: begin
          if (bus.chout_ready) begin
            if (slot_q >= maxseq_q) begin
              slot_q  <= '0;
              state_q <= StWaitResp;
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
        end
        StWaitResp: begin
          if (commit) begin
            resp_ctr_q <= '0;
            state_q    <= ctrl_q[CtrlCont] ? StRun : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.chout_valid         = (state_q == StRun);
  assign bus.chout_data          = cmd_ch;
  assign bus.chout_startofpacket = (slot_q == 4'd0);
  assign bus.chout_endofpacket   = (slot_q == maxseq_q);
  assign irq_out                 = irq_q;

  adc_seq_result_bank #(
    .DEPTH  (SEQ_DEPTH),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (resp_store),
    .wr_idx  (resp_idx[3:0]),
    .wr_data (bus.resp_data),
    .commit  (commit),
    .rd_idx  (bus.MMS_address[3:0]),
    .rd_data (bank_rd_data)
  );

`ifdef ADC_SEQ_TIMESTAMP_EN
  logic [31:0] cycle_cnt_q, ts_cap_q, ts_q;
  logic        trig_accept;

  assign trig_accept = (state_q == StIdle) && trig_edge && ctrl_q[CtrlEn] && en_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      ts_cap_q    <= '0;
      ts_q        <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (trig_accept) ts_cap_q <= cycle_cnt_q;
      if (commit)      ts_q     <= ts_cap_q;
    end
  end
  assign ts_rdata = ts_q;
`else
  assign ts_rdata = '0;
`endif

  always_comb begin
    bus.MMS_readdata = '0;
    case (bus.MMS_address)
      AddrCtrl:   bus.MMS_readdata = 32'(ctrl_q);
      AddrStatus: bus.MMS_readdata = 32'(status_q);
      AddrIrqEn:  bus.MMS_readdata = 32'(irq_en_q);
      AddrMaxSeq: bus.MMS_readdata = 32'(maxseq_q);
      AddrTstamp: bus.MMS_readdata = ts_rdata;
      default: ;
    endcase
    if (bus.MMS_address[5:4] == PageChMap) begin
      for (int i = 0; i < int'(SEQ_DEPTH); i++) begin
        if (bus.MMS_address[3:0] == 4'(i)) bus.MMS_readdata = 32'(ch_map_q[i]);
      end
    end
    if (bus.MMS_address[5:4] == PageResult) bus.MMS_readdata = 32'(bank_rd_data);
  end

endmodule
